// File: rtl/light_pkg.sv
// Shared definitions for the bike-light mode controller.
// Holds the one-hot mode encoding, the binary status codes and the
// one-hot to binary conversion used for the status LED outputs.
package light_pkg;

    typedef enum logic [3:0] {
        MODE_OFF   = 4'b0001,
        MODE_ON    = 4'b0010,
        MODE_BLINK = 4'b0100,
        MODE_DIM   = 4'b1000
    } mode_t;

    localparam logic [1:0] CODE_OFF   = 2'd0;
    localparam logic [1:0] CODE_ON    = 2'd1;
    localparam logic [1:0] CODE_BLINK = 2'd2;
    localparam logic [1:0] CODE_DIM   = 2'd3;

    function automatic logic [1:0] onehot_to_code(input logic [3:0] oh);
        logic [1:0] code;
        code = CODE_OFF;
        case (oh)
            MODE_ON:    code = CODE_ON;
            MODE_BLINK: code = CODE_BLINK;
            MODE_DIM:   code = CODE_DIM;
            default:    code = CODE_OFF;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button front end: two-flop synchroniser, stability debounce and
// press detector.
// Ports:
//   clk       system clock
//   rst_n     synchronous active-low reset
//   btn_raw   asynchronous raw button level, 1 = pressed
//   level     debounced button level
//   press_evt one-cycle pulse the cycle after level rises 0->1
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 1250000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic level,
    output logic press_evt
);
    import light_pkg::*;

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync_q1;
    logic          btn_s;
    logic          level_d;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q1   <= 1'b0;
            btn_s     <= 1'b0;
            level     <= 1'b0;
            level_d   <= 1'b0;
            press_evt <= 1'b0;
            cnt       <= '0;
        end else begin
            sync_q1   <= btn_raw;
            btn_s     <= sync_q1;
            level_d   <= level;
            press_evt <= level & ~level_d;
            // Any return to the accepted level restarts the stability count,
            // so a glitch shorter than DEBOUNCE_CYCLES never flips level.
            if (btn_s == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                level <= btn_s;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/light_mode_controller.sv
// Bike-light mode controller: steps OFF->ON->BLINK->DIM->OFF on each
// accepted button press and drives the LED waveform for the active mode.
// Ports:
//   clk       system clock
//   rst_n     synchronous active-low reset
//   btn_raw   asynchronous raw button level, 1 = pressed
//   force_off holds the mode at OFF while high; presses are ignored
//   state     one-hot mode (bit0 OFF, bit1 ON, bit2 BLINK, bit3 DIM)
//   mode_code binary mode (OFF=0, ON=1, BLINK=2, DIM=3)
//   led_out   registered LED drive
//   press_evt one-cycle pulse per accepted press
module light_mode_controller #(
    parameter int DEBOUNCE_CYCLES = 1250000,
    parameter int BLINK_HALF      = 31250000,
    parameter int PWM_BITS        = 8,
    parameter int DIM_DUTY        = 32,
    parameter int IDLE_TIMEOUT    = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_raw,
    input  logic       force_off,
    output logic [3:0] state,
    output logic [1:0] mode_code,
    output logic       led_out,
    output logic       press_evt
);
    import light_pkg::*;

    localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam int IW = (IDLE_TIMEOUT > 1) ? $clog2(IDLE_TIMEOUT) : 1;
    localparam logic [BW-1:0]     BLINK_LAST = BW'(BLINK_HALF - 1);
    localparam logic [IW-1:0]     IDLE_LAST  = IW'((IDLE_TIMEOUT > 0) ? IDLE_TIMEOUT - 1 : 0);
    // One bit wider than the counter so DIM_DUTY = 2^PWM_BITS means always on.
    localparam logic [PWM_BITS:0] DUTY_LIMIT = (PWM_BITS + 1)'(DIM_DUTY);

    mode_t               mode_q;
    mode_t               mode_nxt;
    logic [BW-1:0]       blink_cnt;
    logic                blink_phase;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic [IW-1:0]       idle_cnt;
    logic                idle_hit;
    // The debounced level is available from the front end but only the
    // press event drives the mode sequence.
    logic                btn_level_unused;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk      (clk),
        .rst_n    (rst_n),
        .btn_raw  (btn_raw),
        .level    (btn_level_unused),
        .press_evt(press_evt)
    );

    assign state     = mode_q;
    assign mode_code = onehot_to_code(mode_q);
    assign idle_hit  = (IDLE_TIMEOUT > 0) && (mode_q != MODE_OFF) && (idle_cnt == IDLE_LAST);

    // Priority: force_off, then press, then idle timeout.
    always_comb begin
        mode_nxt = mode_q;
        if (force_off) begin
            mode_nxt = MODE_OFF;
        end else if (press_evt) begin
            case (mode_q)
                MODE_OFF:   mode_nxt = MODE_ON;
                MODE_ON:    mode_nxt = MODE_BLINK;
                MODE_BLINK: mode_nxt = MODE_DIM;
                default:    mode_nxt = MODE_OFF;
            endcase
        end else if (idle_hit) begin
            mode_nxt = MODE_OFF;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mode_q      <= MODE_OFF;
            led_out     <= 1'b0;
            blink_cnt   <= '0;
            blink_phase <= 1'b1;
            pwm_cnt     <= '0;
            idle_cnt    <= '0;
        end else begin
            mode_q <= mode_nxt;

            case (mode_q)
                MODE_ON:    led_out <= 1'b1;
                MODE_BLINK: led_out <= blink_phase;
                MODE_DIM:   led_out <= ({1'b0, pwm_cnt} < DUTY_LIMIT);
                default:    led_out <= 1'b0;
            endcase

            // Counters only run while staying in their own mode, so each
            // entry starts from 0 (and BLINK from the on-phase).
            if (mode_q == MODE_BLINK && mode_nxt == MODE_BLINK) begin
                if (blink_cnt == BLINK_LAST) begin
                    blink_cnt   <= '0;
                    blink_phase <= ~blink_phase;
                end else begin
                    blink_cnt <= blink_cnt + 1'b1;
                end
            end else begin
                blink_cnt   <= '0;
                blink_phase <= 1'b1;
            end

            if (mode_q == MODE_DIM && mode_nxt == MODE_DIM) begin
                pwm_cnt <= pwm_cnt + 1'b1;
            end else begin
                pwm_cnt <= '0;
            end

            if (IDLE_TIMEOUT == 0 || mode_q == MODE_OFF || press_evt ||
                mode_nxt != mode_q || idle_hit) begin
                idle_cnt <= '0;
            end else begin
                idle_cnt <= idle_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_light_mode_controller.sv
// Directed bench for light_mode_controller. dut0 runs without idle timeout,
// dut1 with a 20-cycle idle timeout; both share clock and inputs.
module tb_light_mode_controller;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       btn_raw = 1'b0;
    logic       force_off = 1'b0;
    logic [3:0] d0_state, d1_state;
    logic [1:0] d0_code, d1_code;
    logic       d0_led, d1_led, d0_pe, d1_pe;
    int         n_cmp = 0;
    int         n_err = 0;
    int         p;
    logic [11:0] blink_pat = 12'b000111000111;
    logic [7:0]  dim_pat   = 8'b00000011;

    always #5 clk = ~clk;

    light_mode_controller #(
        .DEBOUNCE_CYCLES(4), .BLINK_HALF(3), .PWM_BITS(3), .DIM_DUTY(2), .IDLE_TIMEOUT(0)
    ) dut0 (
        .clk(clk), .rst_n(rst_n), .btn_raw(btn_raw), .force_off(force_off),
        .state(d0_state), .mode_code(d0_code), .led_out(d0_led), .press_evt(d0_pe)
    );

    light_mode_controller #(
        .DEBOUNCE_CYCLES(4), .BLINK_HALF(3), .PWM_BITS(3), .DIM_DUTY(2), .IDLE_TIMEOUT(20)
    ) dut1 (
        .clk(clk), .rst_n(rst_n), .btn_raw(btn_raw), .force_off(force_off),
        .state(d1_state), .mode_code(d1_code), .led_out(d1_led), .press_evt(d1_pe)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Full clean press and release on dut0; returns the press_evt count seen.
    task automatic press(output int pulses);
        pulses = 0;
        btn_raw = 1'b1;
        repeat (10) begin
            step();
            if (d0_pe) pulses++;
        end
        btn_raw = 1'b0;
        repeat (10) begin
            step();
            if (d0_pe) pulses++;
        end
    endtask

    initial begin
        // Reset values
        rst_n = 1'b0;
        repeat (2) step();
        chk("rst_state", d0_state, 4'b0001);
        chk("rst_code", d0_code, 2'd0);
        chk("rst_led", d0_led, 1'b0);
        chk("rst_pe", d0_pe, 1'b0);
        chk("rst_state_d1", d1_state, 4'b0001);
        rst_n = 1'b1;
        repeat (3) step();

        // Press latency: btn set now, sampled next edge
        btn_raw = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            step();
            chk("lat_pe", d0_pe, k == 7);
            chk("lat_state", d0_state, (k >= 8) ? 4'b0010 : 4'b0001);
            chk("lat_code", d0_code, (k >= 8) ? 2'd1 : 2'd0);
            chk("lat_led", d0_led, k >= 9);
        end
        btn_raw = 1'b0;
        repeat (10) step();

        // ON -> BLINK and blink waveform
        btn_raw = 1'b1;
        repeat (8) step();
        chk("blink_state", d0_state, 4'b0100);
        chk("blink_code", d0_code, 2'd2);
        btn_raw = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            chk("blink_led", d0_led, blink_pat[i]);
        end

        // BLINK -> DIM and PWM waveform
        btn_raw = 1'b1;
        repeat (8) step();
        chk("dim_state", d0_state, 4'b1000);
        chk("dim_code", d0_code, 2'd3);
        btn_raw = 1'b0;
        for (int i = 0; i < 16; i++) begin
            step();
            chk("dim_led", d0_led, dim_pat[i % 8]);
        end

        // DIM -> OFF wrap
        press(p);
        chk("wrap_pulses", p, 1);
        chk("wrap_state", d0_state, 4'b0001);
        chk("wrap_code", d0_code, 2'd0);
        chk("wrap_led", d0_led, 1'b0);

        // 3-cycle glitch is rejected
        p = 0;
        btn_raw = 1'b1;
        repeat (3) begin
            step();
            if (d0_pe) p++;
        end
        btn_raw = 1'b0;
        repeat (10) begin
            step();
            if (d0_pe) p++;
        end
        chk("glitch_pulses", p, 0);
        chk("glitch_state", d0_state, 4'b0001);

        // Bounce 1,0,1,0 then steady high gives one press
        p = 0;
        for (int i = 0; i < 4; i++) begin
            btn_raw = (i % 2 == 0);
            step();
            if (d0_pe) p++;
        end
        press(p);
        chk("bounce_pulses", p, 1);
        chk("bounce_state", d0_state, 4'b0010);

        // force_off from BLINK
        press(p);
        chk("force_pre_state", d0_state, 4'b0100);
        force_off = 1'b1;
        step();
        chk("force_state", d0_state, 4'b0001);
        step();
        chk("force_led", d0_led, 1'b0);
        press(p);
        chk("force_pulses", p, 1);
        chk("force_hold_state", d0_state, 4'b0001);
        force_off = 1'b0;
        repeat (3) step();
        chk("force_rel_state", d0_state, 4'b0001);
        chk("force_rel_led", d0_led, 1'b0);

        // Reset while in DIM
        press(p);
        press(p);
        press(p);
        chk("pre_rst_state", d0_state, 4'b1000);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("rst_dim_state", d0_state, 4'b0001);
        chk("rst_dim_code", d0_code, 2'd0);
        chk("rst_dim_led", d0_led, 1'b0);
        chk("rst_dim_pe", d0_pe, 1'b0);

        // Reset mid-debounce discards the pending press
        btn_raw = 1'b1;
        repeat (4) step();
        rst_n = 1'b0;
        btn_raw = 1'b0;
        step();
        rst_n = 1'b1;
        chk("rst_mid_state", d0_state, 4'b0001);
        chk("rst_mid_pe", d0_pe, 1'b0);
        p = 0;
        repeat (12) begin
            step();
            if (d0_pe) p++;
        end
        chk("rst_mid_pulses", p, 0);
        chk("rst_mid_state2", d0_state, 4'b0001);

        // Idle timeout on dut1
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        chk("idle_start", d1_state, 4'b0001);
        btn_raw = 1'b1;
        for (int k = 1; k <= 28; k++) begin
            step();
            if (k == 10) btn_raw = 1'b0;
            if (k == 8)  chk("idle_on", d1_state, 4'b0010);
            if (k == 27) chk("idle_last_on", d1_state, 4'b0010);
            if (k == 28) begin
                chk("idle_off", d1_state, 4'b0001);
                chk("idle_off_code", d1_code, 2'd0);
                chk("noidle_on", d0_state, 4'b0010);
            end
        end

        // Press lands in the timeout cycle: advances and restarts the timer
        btn_raw = 1'b1;
        for (int k = 1; k <= 48; k++) begin
            step();
            if (k == 10) btn_raw = 1'b0;
            if (k == 20) btn_raw = 1'b1;
            if (k == 30) btn_raw = 1'b0;
            if (k == 8)  chk("tp_on", d1_state, 4'b0010);
            if (k == 27) begin
                chk("tp_pe", d1_pe, 1'b1);
                chk("tp_on_last", d1_state, 4'b0010);
            end
            if (k == 28) chk("tp_blink", d1_state, 4'b0100);
            if (k == 47) chk("tp_blink_last", d1_state, 4'b0100);
            if (k == 48) chk("tp_off", d1_state, 4'b0001);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/light_mode_controller.md
Name: light_mode_controller

Overview:
Sequences the bike-light output through its operating modes from a single raw push-button, and generates the LED drive waveform for each mode. Contains button synchronisation/debounce, the mode state machine, a blink timer, a dim PWM generator and an idle auto-off timer. Sits directly behind the board button and ahead of the LED pins in the FPGA top level. Exports a one-hot mode vector and a 2-bit mode code for status LEDs.

Parameters:
DEBOUNCE_CYCLES, 1250000, cycles the synchronised button must be stable before it is accepted (10 ms at 125 MHz); minimum 1
BLINK_HALF, 31250000, cycles per blink half-period (250 ms at 125 MHz); minimum 1
PWM_BITS, 8, width of the dim PWM counter
DIM_DUTY, 32, high cycles per 2^PWM_BITS PWM period in DIM; must be less than or equal to 2^PWM_BITS
IDLE_TIMEOUT, 0, cycles without a press before automatic return to OFF; 0 disables the timeout

Ports:
clk  input  1  system clock
rst_n  input  1  synchronous active-low reset
btn_raw  input  1  asynchronous raw button level, 1 = pressed
force_off  input  1  level; when 1, mode is held at OFF and presses are ignored
state  output  4  one-hot mode: bit0 OFF, bit1 ON, bit2 BLINK, bit3 DIM
mode_code  output  2  binary mode: OFF=0, ON=1, BLINK=2, DIM=3; equals {state[2]|state[3], state[1]|state[3]}
led_out  output  1  LED drive
press_evt  output  1  one-cycle pulse on each accepted press

Behaviour:
- One clock, clk. Reset is synchronous and active-low: rst_n sampled low at a clk rising edge resets the block. All state is registered.
- Reset values: state=0001, mode_code=0, led_out=0, press_evt=0. All counters are 0, and both synchroniser flops and the debounced level are 0.
- Sync: btn_raw passes through a 2-flop synchroniser to give btn_s.
- Debounce: while btn_s equals the debounced level, the counter is 0. Otherwise the counter increments. When the counter reaches DEBOUNCE_CYCLES-1 on a clock edge, the debounced level takes the value of btn_s and the counter clears. A glitch shorter than DEBOUNCE_CYCLES cycles never changes the level.
- press_evt is high for exactly one cycle, the cycle after the debounced level rises 0->1. Release generates no event.
- Latency: btn_raw held high from edge N gives press_evt high in cycle N+2+DEBOUNCE_CYCLES. state updates on the edge that ends the press_evt cycle.
- FSM on press_evt: OFF->ON->BLINK->DIM->OFF, wrapping after DIM.
- force_off=1: the next state is OFF regardless of other events. press_evt still pulses but does not advance the mode. After release the mode stays OFF.
- Idle timer: active only when IDLE_TIMEOUT>0 and the mode is not OFF. It clears on press_evt and on any mode change, and otherwise increments. When it reaches IDLE_TIMEOUT-1, the next state is OFF and the timer clears.
- Priority in one cycle: rst_n low, then force_off, then press_evt, then idle timeout. A press in the same cycle as the timeout advances the mode and restarts the timer.
- led_out is registered and has 1 cycle of latency from state:
  - OFF: 0.
  - ON: 1.
  - BLINK: phase flag. Entering BLINK sets phase=1 and blink counter=0. The counter runs 0..BLINK_HALF-1, and phase toggles on wrap. The first on-interval is therefore BLINK_HALF cycles.
  - DIM: PWM counter is free-running modulo 2^PWM_BITS and clears on entering DIM. led_out = (pwm_cnt < DIM_DUTY). DIM_DUTY=0 gives constant 0; DIM_DUTY=2^PWM_BITS gives constant 1.
- Blink and PWM counters hold at 0 outside their own modes.
- Reset mid-operation, in any mode or mid-debounce, returns to the reset values on that edge. A press that has not yet been accepted is discarded.

Decomposition:
- Shared package light_pkg holds:
  - the mode enum with one-hot constants MODE_OFF/ON/BLINK/DIM (4'b0001/0010/0100/1000);
  - the binary code constants 0..3;
  - a function converting one-hot to code.
- One sub-module, btn_debounce (parameter DEBOUNCE_CYCLES; ports clk, rst_n, btn_raw, level, press_evt), containing the synchroniser, debounce counter and rising-edge detector.
- The FSM, timers and PWM remain in light_mode_controller.

Test Plan:
- Parameters DEBOUNCE_CYCLES=4, BLINK_HALF=3, PWM_BITS=3, DIM_DUTY=2, IDLE_TIMEOUT=0.
  - Reset, then btn_raw=1 held from cycle 10 -> press_evt high only in cycle 16; state=0010 and mode_code=1 from cycle 17; led_out=1 from cycle 18.
  - Four clean presses -> state sequence 0001, 0010, 0100, 1000, 0001.
  - In BLINK -> led_out pattern 1,1,1,0,0,0 repeating.
  - In DIM -> led_out 1,1,0,0,0,0,0,0 repeating.
  - btn_raw pulses 3 cycles high, then low -> no press_evt and state unchanged.
  - Bounce 1,0,1,0 then steady high -> exactly one press_evt.
- Same parameters except IDLE_TIMEOUT=20.
  - In ON with no presses -> state returns to 0001 exactly 20 cycles after entering ON.
  - A press arriving in the timeout cycle -> advances to BLINK and the timer restarts.
- force_off=1 while in BLINK -> state=0001 on the next edge and led_out=0 one cycle later. A press during force_off -> press_evt pulses, state stays 0001. After release, state remains 0001.
- rst_n=0 for one edge while in DIM, and mid-debounce -> all outputs return to reset values. The pending press produces no press_evt after reset.
